axi_rd_arbiter: RTL and testbench
=================================

Name: axi_rd_arbiter

Overview:
- Shares one AXI4 read channel (AR/R) between four requesters: uncached data (dsram), dcache refill, uncached fetch (isram) and icache refill.
- Sits between the cache/uncached front ends and the SoC AXI master port.
- Keeps one transaction outstanding, uses fixed priority with instruction-side anti-starvation, and blocks reads that hit a line currently being written back.

Parameters:
- NREQ, 4, number of requesters; index 0 dsram, 1 dcache, 2 isram, 3 icache; lower index means higher priority.
- LINE_BYTE_OFFSET, 6, low address bits ignored in the write-hazard line compare.
- STARVE_LIMIT, 4, number of consecutive data-side grants after which a waiting instruction requester wins.
- ID_WIDTH, 4, AXI ID width.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset
- i_req_valid  in  NREQ  request pending, per requester; held until accepted
- i_req_addr  in  NREQ*32  start byte address; requester k uses bits [32k+31:32k]
- i_req_len  in  NREQ*8  AXI burst length minus 1
- i_req_size  in  NREQ*3  AXI beat size
- o_req_ready  out  NREQ  one-cycle pulse: request accepted (latched)
- o_rvalid  out  NREQ  beat valid for the owning requester
- o_rdata  out  32  beat data, shared by all requesters
- o_rlast  out  1  final beat
- o_rerr  out  1  rresp != OKAY on the current beat
- i_write_process  in  1  writeback in flight
- i_write_addr  in  32  address of the line being written back
- arid/araddr/arlen/arsize/arburst/arvalid  out  ID_WIDTH/32/8/3/2/1  AXI AR
- arready  in  1
- rid/rdata/rresp/rlast/rvalid  in  ID_WIDTH/32/2/1/1  AXI R
- rready  out  1

Behaviour:
- Reset (already decided): one clock; reset is asynchronous and active-high. While reset is asserted, the FSM goes to IDLE.
  - All outputs are 0 except arburst, which is 2'b01.
  - Reset mid-burst abandons the transaction; no o_rvalid is issued afterwards.
- Request eligibility: requester k is eligible iff i_req_valid[k] && !(i_write_process && addr_k[31:LINE_BYTE_OFFSET] == i_write_addr[31:LINE_BYTE_OFFSET]).
- FSM IDLE:
  - If any requester is eligible, pick a winner. Default is the lowest eligible index.
  - If starve_cnt == STARVE_LIMIT and index 2 or 3 is eligible, the lowest eligible of {2,3} wins.
  - In the same cycle: pulse o_req_ready[winner], latch addr/len/size, set owner = winner, go to AR.
  - If nothing is eligible, stay in IDLE.
- FSM AR:
  - arvalid=1; araddr/arlen/arsize come from the latch; arid = owner zero-extended; arburst = INCR.
  - Payload is stable while arvalid && !arready.
  - On arready, go to R. arvalid falls the next cycle.
- FSM R:
  - rready=1.
  - o_rvalid[owner] = rvalid; o_rdata = rdata; o_rlast = rlast && rvalid; o_rerr = rvalid && rresp != 0. All of these are combinational pass-through with zero added latency.
  - On rvalid && rlast, go to IDLE. The next arbitration happens in the cycle after the last beat, so the minimum gap between bursts is 1 idle cycle.
  - rid is not checked; only one transaction is ever outstanding.
- Starvation counter (width clog2(STARVE_LIMIT+1)):
  - On a grant to index 0 or 1 while index 2 or 3 has i_req_valid: increment, saturating at STARVE_LIMIT.
  - On any grant to index 2 or 3: clear to 0.
  - Otherwise: hold.
- Requests that arrive or drop while the FSM is busy have no effect until IDLE.
- A requester must not deassert i_req_valid before o_req_ready. If it does, the request is simply not considered; there is no error.
- Hazard rules:
  - A hazard is evaluated only in IDLE.
  - A grant already issued is not revoked if i_write_process rises later.
  - A blocked requester stays pending; lower-priority eligible requesters may win past it.
- Outputs are 0 whenever not in the state that drives them.

Test Plan:
- Single icache refill: i_req_valid=4'b1000, addr 0x1FC0_0040, len 15, size 2 → o_req_ready[3] pulses 1 cycle; araddr 0x1FC0_0040, arlen 15, arid 3. Sixteen o_rvalid[3] beats follow, with o_rlast on the 16th. The FSM returns to IDLE the cycle after.
- Priority: all four valid on the same cycle, arready and rvalid always 1, len 0 each, instruction requests held → grants go 0, 1, 2, 3. Counter check: with index 3 held continuously and index 0 re-requesting, after 4 data grants the next grant goes to index 3.
- AR backpressure: arready low for 5 cycles → arvalid stays 1 and araddr stays stable throughout; o_req_ready pulses only once.
- Write hazard: i_write_process=1, i_write_addr 0x0000_1040, dcache request at 0x0000_1060 (same 64B line), icache request at 0x0000_2000 → icache is granted and dcache stays blocked. Dropping i_write_process → dcache is granted next IDLE.
- Error response: rresp=2'b10 on beat 3 of a 4-beat burst → o_rerr=1 on that beat only; the burst still completes and the FSM returns to IDLE.
- Async reset in R after beat 2 of 8 → all outputs 0 immediately with no clock edge; after release the FSM is in IDLE and a new request is granted normally.

Source files
------------

// File: rtl/axi_rd_arbiter_if.sv
// -----------------------------------------------------------------------------
// axi_rd_arbiter_if
// AXI4 read-address / read-data channel bundle between the read arbiter and
// the SoC AXI master port.
//   master modport : arbiter side (drives AR payload/arvalid and rready)
//   slave  modport : interconnect side (drives arready and the R channel)
// -----------------------------------------------------------------------------
interface axi_rd_arbiter_if #(
    parameter int ID_WIDTH = 4
);
    // AR channel
    logic [ID_WIDTH-1:0] arid;
    logic [31:0]         araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arvalid;
    logic                arready;
    // R channel
    logic [ID_WIDTH-1:0] rid;
    logic [31:0]         rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/axi_rd_arbiter.sv
// -----------------------------------------------------------------------------
// axi_rd_arbiter
// Shares one AXI4 read channel between four requesters:
//   0 dsram (uncached data), 1 dcache refill, 2 isram (uncached fetch),
//   3 icache refill. Lower index has higher priority, except that after
//   STARVE_LIMIT consecutive data-side grants a waiting instruction-side
//   requester wins. Only one transaction is outstanding at a time. Requests
//   whose line matches the line currently being written back are held off.
// Ports:
//   i_clk, i_rst            clock, asynchronous active-high reset
//   i_req_valid/addr/len/size  per-requester request (packed, 32/8/3 bits each)
//   o_req_ready             one-cycle accept pulse per requester
//   o_rvalid/o_rdata/o_rlast/o_rerr  read beat returned to the owner
//   i_write_process/i_write_addr     writeback-in-flight line for hazard check
//   axi                     AXI AR/R master port
// -----------------------------------------------------------------------------
module axi_rd_arbiter #(
    parameter int NREQ             = 4,
    parameter int LINE_BYTE_OFFSET = 6,
    parameter int STARVE_LIMIT     = 4,
    parameter int ID_WIDTH         = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [NREQ-1:0]      i_req_valid,
    input  logic [NREQ*32-1:0]   i_req_addr,
    input  logic [NREQ*8-1:0]    i_req_len,
    input  logic [NREQ*3-1:0]    i_req_size,
    output logic [NREQ-1:0]      o_req_ready,
    output logic [NREQ-1:0]      o_rvalid,
    output logic [31:0]          o_rdata,
    output logic                 o_rlast,
    output logic                 o_rerr,
    input  logic                 i_write_process,
    input  logic [31:0]          i_write_addr,
    axi_rd_arbiter_if.master     axi
);
    localparam int OWN_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W  = $clog2(STARVE_LIMIT + 1);
    localparam int TAG_W  = 32 - LINE_BYTE_OFFSET;
    // Instruction-side requester indices (anti-starvation candidates)
    localparam int IDX_I0 = 2;
    localparam int IDX_I1 = 3;
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AR   = 2'd1,
        ST_R    = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_next_s;
    logic [NREQ-1:0]     eligible_s;
    logic                any_s;
    logic                instr_elig_s;
    logic [OWN_W-1:0]    winner_s;
    logic                grant_s;
    logic                winner_instr_s;
    logic [31:0]         sel_addr_s;
    logic [7:0]          sel_len_s;
    logic [2:0]          sel_size_s;

    logic [31:0]         addr_r;
    logic [7:0]          len_r;
    logic [2:0]          size_r;
    logic [OWN_W-1:0]    owner_r;
    logic [CNT_W-1:0]    starve_r;

    logic [ID_WIDTH-1:0] arid_s;
    logic [31:0]         araddr_s;
    logic [7:0]          arlen_s;
    logic [2:0]          arsize_s;
    logic                arvalid_s;
    logic                rready_s;

    // rid is ignored (single outstanding transaction) and the in-line byte
    // offset of the writeback address plays no role in the line compare.
    logic                rid_unused_s;
    assign rid_unused_s = ^{axi.rid, i_write_addr[LINE_BYTE_OFFSET-1:0]};

    // Request eligibility: pending and not hitting the line under writeback
    always_comb begin
        eligible_s = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (i_req_valid[k] && !(i_write_process &&
                (i_req_addr[32*k+LINE_BYTE_OFFSET +: TAG_W] ==
                 i_write_addr[31:LINE_BYTE_OFFSET]))) begin
                eligible_s[k] = 1'b1;
            end else begin
                eligible_s[k] = 1'b0;
            end
        end
    end

    // Winner select: lowest eligible index, overridden by the instruction
    // side once the data side has won STARVE_LIMIT times in a row
    always_comb begin
        any_s        = |eligible_s;
        instr_elig_s = eligible_s[IDX_I0] | eligible_s[IDX_I1];
        winner_s     = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (eligible_s[k]) begin
                winner_s = OWN_W'(k);
            end else begin
                winner_s = winner_s;
            end
        end
        if ((starve_r == STARVE_MAX) && instr_elig_s) begin
            winner_s = eligible_s[IDX_I0] ? OWN_W'(IDX_I0) : OWN_W'(IDX_I1);
        end else begin
            winner_s = winner_s;
        end
        grant_s        = (state_r == ST_IDLE) && any_s;
        winner_instr_s = (winner_s == OWN_W'(IDX_I0)) || (winner_s == OWN_W'(IDX_I1));
    end

    // Request payload mux for the current winner
    always_comb begin
        sel_addr_s = 32'd0;
        sel_len_s  = 8'd0;
        sel_size_s = 3'd0;
        for (int k = 0; k < NREQ; k++) begin
            if (winner_s == OWN_W'(k)) begin
                sel_addr_s = i_req_addr[32*k +: 32];
                sel_len_s  = i_req_len[8*k +: 8];
                sel_size_s = i_req_size[3*k +: 3];
            end else begin
                sel_addr_s = sel_addr_s;
            end
        end
    end

    // FSM state register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (any_s) begin
                    state_next_s = ST_AR;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_AR: begin
                if (axi.arready) begin
                    state_next_s = ST_R;
                end else begin
                    state_next_s = ST_AR;
                end
            end
            ST_R: begin
                if (axi.rvalid && axi.rlast) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_R;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // FSM outputs; the R path is a zero-latency pass-through to the owner
    always_comb begin
        o_req_ready = '0;
        o_rvalid    = '0;
        o_rdata     = 32'd0;
        o_rlast     = 1'b0;
        o_rerr      = 1'b0;
        arid_s      = '0;
        araddr_s    = 32'd0;
        arlen_s     = 8'd0;
        arsize_s    = 3'd0;
        arvalid_s   = 1'b0;
        rready_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // Reset is asynchronous; keep the accept pulse quiet while it
                // is held even though arbitration inputs may be active.
                if (any_s && !i_rst) begin
                    for (int k = 0; k < NREQ; k++) begin
                        o_req_ready[k] = (winner_s == OWN_W'(k));
                    end
                end else begin
                    o_req_ready = '0;
                end
            end
            ST_AR: begin
                arvalid_s = 1'b1;
                araddr_s  = addr_r;
                arlen_s   = len_r;
                arsize_s  = size_r;
                arid_s    = ID_WIDTH'(owner_r);
            end
            ST_R: begin
                rready_s          = 1'b1;
                o_rvalid[owner_r] = axi.rvalid;
                o_rdata           = axi.rdata;
                o_rlast           = axi.rlast && axi.rvalid;
                o_rerr            = axi.rvalid && (axi.rresp != 2'b00);
            end
            default: begin
                rready_s = 1'b0;
            end
        endcase
    end

    // Latch the winning request so the AR payload stays stable under backpressure
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            addr_r  <= 32'd0;
            len_r   <= 8'd0;
            size_r  <= 3'd0;
            owner_r <= '0;
        end else if (grant_s) begin
            addr_r  <= sel_addr_s;
            len_r   <= sel_len_s;
            size_r  <= sel_size_s;
            owner_r <= winner_s;
        end
    end

    // Count data-side grants made while an instruction request was waiting
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            starve_r <= '0;
        end else if (grant_s) begin
            if (winner_instr_s) begin
                starve_r <= '0;
            end else if ((i_req_valid[IDX_I0] || i_req_valid[IDX_I1]) &&
                         (starve_r != STARVE_MAX)) begin
                starve_r <= starve_r + CNT_W'(1);
            end
        end
    end

    assign axi.arid    = arid_s;
    assign axi.araddr  = araddr_s;
    assign axi.arlen   = arlen_s;
    assign axi.arsize  = arsize_s;
    assign axi.arburst = 2'b01;
    assign axi.arvalid = arvalid_s;
    assign axi.rready  = rready_s;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// -----------------------------------------------------------------------------
// tb_axi_rd_arbiter
// Self-checking bench: directed scenarios followed by randomized traffic, all
// compared against a transaction-level model of the arbitration rules.
// -----------------------------------------------------------------------------
module tb_axi_rd_arbiter;
    localparam int LIMIT = 4;

    logic         clk;
    logic         rst;
    logic [3:0]   req_valid;
    logic [127:0] req_addr;
    logic [31:0]  req_len;
    logic [11:0]  req_size;
    logic [3:0]   o_req_ready;
    logic [3:0]   o_rvalid;
    logic [31:0]  o_rdata;
    logic         o_rlast;
    logic         o_rerr;
    logic         write_process;
    logic [31:0]  write_addr;

    axi_rd_arbiter_if #(.ID_WIDTH(4)) axi ();

    axi_rd_arbiter #(
        .NREQ(4), .LINE_BYTE_OFFSET(6), .STARVE_LIMIT(LIMIT), .ID_WIDTH(4)
    ) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid), .i_req_addr(req_addr),
        .i_req_len(req_len), .i_req_size(req_size),
        .o_req_ready(o_req_ready), .o_rvalid(o_rvalid), .o_rdata(o_rdata),
        .o_rlast(o_rlast), .o_rerr(o_rerr),
        .i_write_process(write_process), .i_write_addr(write_addr),
        .axi(axi)
    );

    // Clock generation
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: pending requests, writeback hazard, starvation count
    bit          pend [4];
    logic [31:0] a    [4];
    logic [7:0]  l    [4];
    logic [2:0]  s    [4];
    bit          wp;
    logic [31:0] waddr;
    int          starve_m;

    // Per-transaction knobs
    bit rnd_on;
    bit gap_on;
    int ar_delay;
    int err_beat;
    int reset_beat;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive_reqs();
        for (int k = 0; k < 4; k++) begin
            req_valid[k]          = pend[k];
            req_addr[32*k +: 32]  = a[k];
            req_len[8*k +: 8]     = l[k];
            req_size[3*k +: 3]    = s[k];
        end
        write_process = wp;
        write_addr    = waddr;
    endtask

    // Eligible list, then: lowest index, unless the data side has starved
    // the instruction side, in which case the first instruction entry wins.
    function automatic int model_pick();
        int elig[$];
        for (int k = 0; k < 4; k++) begin
            if (pend[k] && !(wp && (a[k] >> 6) == (waddr >> 6))) elig.push_back(k);
        end
        if (elig.size() == 0) return -1;
        if (starve_m == LIMIT) begin
            foreach (elig[i]) if (elig[i] >= 2) return elig[i];
        end
        return elig[0];
    endfunction

    task automatic model_grant(input int w);
        if (w >= 2) starve_m = 0;
        else if (pend[2] || pend[3]) starve_m = (starve_m + 1 > LIMIT) ? LIMIT : starve_m + 1;
    endtask

    task automatic raise_random();
        for (int k = 0; k < 4; k++) begin
            if (!pend[k] && $urandom_range(0, 3) == 0) begin
                pend[k] = 1'b1;
                a[k] = 32'h0000_1000 + 32'($urandom_range(0, 7) << 6) + 32'($urandom_range(0, 15) << 2);
                l[k] = 8'($urandom_range(0, 5));
                s[k] = 3'd2;
            end
        end
        wp    = ($urandom_range(0, 3) == 0);
        waddr = 32'h0000_1000 + 32'($urandom_range(0, 7) << 6) + 32'($urandom_range(0, 63));
    endtask

    task automatic idle_checks(input logic [3:0] exp_rdy);
        check_eq("req_ready", 64'(o_req_ready), 64'(exp_rdy));
        check_eq("idle_arvalid", 64'(axi.arvalid), 64'd0);
        check_eq("idle_rready", 64'(axi.rready), 64'd0);
        check_eq("idle_rvalid", 64'(o_rvalid), 64'd0);
    endtask

    // One cycle with nothing eligible in the model
    task automatic idle_cycle();
        drive_reqs();
        @(negedge clk);
        check_eq("idle_pick", 64'(model_pick() + 1), 64'd0);
        idle_checks(4'b0000);
        @(posedge clk); #1;
    endtask

    // Arbitrate, issue AR, and return the whole burst; w = granted index
    task automatic run_txn(output int w);
        int cycles;
        int d;
        int beats;
        int eb;
        logic [31:0] ea;
        logic [7:0]  el;
        logic [2:0]  es;
        logic [3:0]  exp_v;
        w = -1;
        cycles = 0;
        ea = 32'd0; el = 8'd0; es = 3'd0;
        while (w < 0) begin
            if (rnd_on) begin
                raise_random();
                if (cycles > 20) begin
                    wp = 1'b0;
                    if (!pend[0]) begin pend[0] = 1'b1; a[0] = 32'h0000_3000; l[0] = 8'd1; s[0] = 3'd2; end
                end
            end
            drive_reqs();
            @(negedge clk);
            w = model_pick();
            exp_v = 4'b0000;
            if (w >= 0) begin
                exp_v[w] = 1'b1;
                ea = a[w]; el = l[w]; es = s[w];
                model_grant(w);
            end
            idle_checks(exp_v);
            @(posedge clk); #1;
            if (w >= 0) pend[w] = 1'b0;
            cycles++;
            if (w < 0 && cycles > 60) begin
                check_eq("grant_timeout", 64'(cycles), 64'd60);
                return;
            end
        end
        eb = err_beat;
        if (rnd_on) eb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, el)) : -1;

        // AR phase with optional backpressure
        d = (ar_delay >= 0) ? ar_delay : int'($urandom_range(0, 3));
        for (int i = 0; i <= d; i++) begin
            axi.arready = (i == d);
            if (rnd_on) raise_random();
            drive_reqs();
            @(negedge clk);
            check_eq("arvalid", 64'(axi.arvalid), 64'd1);
            check_eq("araddr", 64'(axi.araddr), 64'(ea));
            check_eq("arlen", 64'(axi.arlen), 64'(el));
            check_eq("arsize", 64'(axi.arsize), 64'(es));
            check_eq("arid", 64'(axi.arid), 64'(w));
            check_eq("arburst", 64'(axi.arburst), 64'd1);
            check_eq("ar_rready", 64'(axi.rready), 64'd0);
            check_eq("ar_req_ready", 64'(o_req_ready), 64'd0);
            @(posedge clk); #1;
        end
        axi.arready = 1'b0;

        // R phase
        beats = 0;
        while (beats <= int'(el)) begin
            if (reset_beat >= 0 && beats == reset_beat) begin
                axi.rvalid = 1'b1; axi.rdata = 32'hDEAD_BEEF; axi.rresp = 2'b10; axi.rlast = 1'b0;
                pend[0] = 1'b1; a[0] = 32'h0000_4000; l[0] = 8'd0; s[0] = 3'd2;
                drive_reqs();
                #1 rst = 1'b1;
                #1;
                check_eq("rst_rvalid", 64'(o_rvalid), 64'd0);
                check_eq("rst_rdata", 64'(o_rdata), 64'd0);
                check_eq("rst_rerr", 64'(o_rerr), 64'd0);
                check_eq("rst_rready", 64'(axi.rready), 64'd0);
                check_eq("rst_req_ready", 64'(o_req_ready), 64'd0);
                check_eq("rst_arburst", 64'(axi.arburst), 64'd1);
                @(posedge clk); #1;
                check_eq("rst_hold_ready", 64'(o_req_ready), 64'd0);
                for (int k = 0; k < 4; k++) pend[k] = 1'b0;
                starve_m = 0;
                rst = 1'b0;
                idle_cycle();
                axi.rvalid = 1'b0; axi.rresp = 2'b00;
                return;
            end
            axi.rvalid = gap_on ? ($urandom_range(0, 2) != 0) : 1'b1;
            axi.rdata  = $urandom;
            axi.rresp  = axi.rvalid ? ((beats == eb) ? 2'b10 : 2'b00) : 2'b11;
            axi.rlast  = axi.rvalid && (beats == int'(el));
            axi.rid    = 4'(w);
            if (rnd_on) raise_random();
            drive_reqs();
            @(negedge clk);
            exp_v = 4'b0000;
            if (axi.rvalid) exp_v[w] = 1'b1;
            check_eq("o_rvalid", 64'(o_rvalid), 64'(exp_v));
            check_eq("o_rdata", 64'(o_rdata), 64'(axi.rdata));
            check_eq("o_rlast", 64'(o_rlast), 64'(axi.rvalid && beats == int'(el)));
            check_eq("o_rerr", 64'(o_rerr), 64'(axi.rvalid && beats == eb));
            check_eq("r_rready", 64'(axi.rready), 64'd1);
            check_eq("r_arvalid", 64'(axi.arvalid), 64'd0);
            check_eq("r_req_ready", 64'(o_req_ready), 64'd0);
            @(posedge clk); #1;
            if (axi.rvalid) beats++;
        end
        axi.rvalid = 1'b0;
        axi.rlast  = 1'b0;
    endtask

    // Global time bound
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin pend[k] = 1'b0; a[k] = 32'd0; l[k] = 8'd0; s[k] = 3'd0; end
        wp = 1'b0; waddr = 32'd0; starve_m = 0;
        rnd_on = 1'b0; gap_on = 1'b0; ar_delay = 0; err_beat = -1; reset_beat = -1;
        axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = 32'd0;
        axi.rresp = 2'b00; axi.rlast = 1'b0; axi.rid = 4'd0;
        pend[0] = 1'b1; a[0] = 32'h0000_0100;
        drive_reqs();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_req_ready", 64'(o_req_ready), 64'd0);
        check_eq("reset_arvalid", 64'(axi.arvalid), 64'd0);
        check_eq("reset_araddr", 64'(axi.araddr), 64'd0);
        check_eq("reset_arburst", 64'(axi.arburst), 64'd1);
        check_eq("reset_rready", 64'(axi.rready), 64'd0);
        check_eq("reset_rvalid", 64'(o_rvalid), 64'd0);
        pend[0] = 1'b0;
        rst = 1'b0;

        // Single icache refill, 16 beats, then IDLE the cycle after
        pend[3] = 1'b1; a[3] = 32'h1FC0_0040; l[3] = 8'd15; s[3] = 3'd2;
        run_txn(w);
        idle_cycle();

        // Fixed priority with all four requesting at once
        for (int k = 0; k < 4; k++) begin
            pend[k] = 1'b1; a[k] = 32'h0000_0200 + 32'(k * 64); l[k] = 8'd0; s[k] = 3'd2;
        end
        for (int i = 0; i < 4; i++) run_txn(w);

        // Anti-starvation: index 3 held, index 0 keeps re-requesting
        pend[3] = 1'b1; a[3] = 32'h0000_0500;
        for (int i = 0; i < 6; i++) begin
            if (!pend[0]) begin pend[0] = 1'b1; a[0] = 32'h0000_0600 + 32'(i * 4); l[0] = 8'd0; end
            run_txn(w);
        end

        // AR backpressure: arready low for 5 cycles
        ar_delay = 5;
        pend[1] = 1'b1; a[1] = 32'h0000_0A00; l[1] = 8'd1; s[1] = 3'd2;
        run_txn(w);
        ar_delay = 0;

        // Write hazard: dcache blocked on the writeback line, icache passes
        wp = 1'b1; waddr = 32'h0000_1040;
        pend[1] = 1'b1; a[1] = 32'h0000_1060; l[1] = 8'd1; s[1] = 3'd2;
        pend[3] = 1'b1; a[3] = 32'h0000_2000; l[3] = 8'd1; s[3] = 3'd2;
        run_txn(w);
        idle_cycle();
        wp = 1'b0;
        run_txn(w);

        // Error response on beat 3 of 4
        err_beat = 2;
        pend[2] = 1'b1; a[2] = 32'h0000_0C00; l[2] = 8'd3; s[2] = 3'd2;
        run_txn(w);
        err_beat = -1;

        // Async reset in R after beat 2 of 8, then a normal request
        reset_beat = 2;
        pend[1] = 1'b1; a[1] = 32'h0000_0D00; l[1] = 8'd7; s[1] = 3'd2;
        run_txn(w);
        reset_beat = -1;
        pend[2] = 1'b1; a[2] = 32'h0000_0E00; l[2] = 8'd2; s[2] = 3'd2;
        run_txn(w);

        // Randomized traffic
        rnd_on = 1'b1; gap_on = 1'b1; ar_delay = -1;
        for (int i = 0; i < 200; i++) run_txn(w);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
